// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared constants for the DMA memory responder
package dma_pkg;

  // Responder FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Latched operation encoding
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  // Read data returned for an out-of-range read
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  // Byte address to word index shift
  localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/dma_mem_array.sv
// rtl/dma_mem_array.sv - single-port synchronous word RAM, one-cycle read latency
module dma_mem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Write when enabled; read data registered every cycle (old data on a same-edge write)
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dma_mem_responder.sv
// rtl/dma_mem_responder.sv - DMA memory-port responder with wait states; optional DMA_MEM_RANGE_CHECK_EN
module dma_mem_responder
  import dma_pkg::*;
#(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic [31:0] rdata_out,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        mem_ready,
  output logic        mem_error
);

  localparam int         AW        = $clog2(DEPTH);
  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          op_q;
  logic          dual_q;
  logic          oor_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;

  logic          borrow;
  logic [31:0]   off;
  logic [31:0]   idx_full;
  logic [AW-1:0] idx_now;
  logic          oor_now;
  logic          req_one;
  logic          req_any;
  logic          wait_last;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic          unused_ok;

  // Address decode: borrow out of the subtraction flags addresses below the window
  always_comb begin
    {borrow, off} = {1'b0, addr_in} - {1'b0, BASE_ADDR};
    idx_full      = off >> WORD_SHIFT;
    idx_now       = idx_full[AW-1:0];
`ifdef DMA_MEM_RANGE_CHECK_EN
    oor_now       = borrow || (idx_full >= 32'(DEPTH));
`else
    oor_now       = 1'b0;
`endif
    req_one       = mem_read ^ mem_write;
    req_any       = mem_read | mem_write;
    wait_last     = (cnt == WAIT_LAST);
  end

  assign unused_ok = ^{borrow, off[1:0], idx_full};

  // RAM port: live address in IDLE (zero-wait path), latched address otherwise.
  // The RAM reads every edge, so the edge entering RESP fetches the requested word.
  always_comb begin
    ram_addr  = (state == ST_IDLE) ? idx_now : idx_q;
    ram_wdata = (state == ST_IDLE) ? wdata_in : wdata_q;
    ram_we    = 1'b0;
    if (reset) begin
      if (state == ST_IDLE) begin
        ram_we = NO_WAIT && req_one && mem_write && !oor_now;
      end else if (state == ST_WAIT) begin
        ram_we = wait_last && (op_q == OP_WR) && !oor_q;
      end
    end
  end

  dma_mem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Response outputs: read data is live in RESP and held in rdata_q afterwards
  always_comb begin
    mem_ready = (state == ST_RESP);
    mem_error = (state == ST_RESP) && (dual_q || oor_q);
    rdata_out = rdata_q;
    if ((state == ST_RESP) && !dual_q && (op_q == OP_RD)) begin
      rdata_out = oor_q ? ERR_RDATA : ram_rdata;
    end
  end

  // Request FSM: accept in IDLE, count wait states, pulse RESP for one cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      op_q    <= OP_RD;
      dual_q  <= 1'b0;
      oor_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            op_q    <= mem_write ? OP_WR : OP_RD;
            dual_q  <= mem_read & mem_write;
            oor_q   <= oor_now;
            idx_q   <= idx_now;
            wdata_q <= wdata_in;
            cnt     <= 4'd0;
            state   <= ((mem_read & mem_write) || NO_WAIT) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_last) begin
            state <= ST_RESP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_RESP: begin
          rdata_q <= rdata_out;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
